ssd_scan_arbiter: RTL and testbench

//  Time-multiplexed scan controller for the 8-digit seven-segment display, shared between two requesters (A, B).

---
 rtl/ssd_scan_arbiter_pkg.sv | 57 +++++
 rtl/ssd_scan_arbiter_if.sv | 39 +++
 rtl/ssd_hex_decoder.sv | 16 +
 rtl/ssd_scan_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_ssd_scan_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_scan_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ssd_scan_arbiter_pkg
//   Shared definitions for the seven-segment scan arbiter and for any other
//   top-level that drives the board SSD. It holds the following items.
//     ssd_state_e       arbiter FSM state encoding (IDLE=00, OWN_A=01, OWN_B=10)
//     SSD_BLANK         cathode pattern for a dark digit (active low, all off)
//     SSD_HEX_SEG       16-entry hex -> {a..g} active-low cathode table
//     lz_blank_mask()   leading-zero blank mask of a 32-bit hex word
//   The optional feature macro SSD_LEADING_ZERO_BLANK_EN is consumed by
//   ssd_scan_arbiter. The helper is always present so that other users can
//   call it.
// ---------------------------------------------------------------------------
package ssd_scan_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwnA = 2'b01,
        StOwnB = 2'b10
    } ssd_state_e;

    localparam logic [6:0] SSD_BLANK = 7'h7F;

    // Bit 6 is segment a, bit 0 is segment g; a 0 lights the segment.
    localparam logic [6:0] SSD_HEX_SEG [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    // Bit k is set when nibble k and every nibble above it are zero.
    // Digit 0 is never blanked, so that a value of zero still shows a single 0.
    function automatic logic [7:0] lz_blank_mask(input logic [31:0] data);
        logic [7:0] mask;
        logic       all_zero_above;
        mask           = '0;
        all_zero_above = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            all_zero_above = all_zero_above && (data[k*4 +: 4] == 4'h0);
            mask[k]        = all_zero_above;
        end
        return mask;
    endfunction

endpackage

// File: rtl/ssd_scan_arbiter_if.sv
// ---------------------------------------------------------------------------
// ssd_scan_arbiter_if
//   Bundles the two requester ports and the display/grant outputs of the
//   seven-segment scan arbiter.
//     Req_A/Req_B      level requests
//     Data_A/Data_B    32-bit hex words; nibble k -> digit k (digit 0 rightmost)
//     Dp_A/Dp_B        dot masks; bit k set lights DP on digit k
//     Gnt_A/Gnt_B      registered grants (never both high)
//     Frame_tick       1-clock pulse at the end of each 8-digit frame
//     An/Cathodes/Dp   active-low board pins
//   The master modport is the requester/board side. The slave modport is the
//   arbiter.
// ---------------------------------------------------------------------------
interface ssd_scan_arbiter_if;

    logic        Req_A;
    logic [31:0] Data_A;
    logic [7:0]  Dp_A;
    logic        Req_B;
    logic [31:0] Data_B;
    logic [7:0]  Dp_B;
    logic        Gnt_A;
    logic        Gnt_B;
    logic        Frame_tick;
    logic [7:0]  An;
    logic [6:0]  Cathodes;
    logic        Dp;

    modport master (
        output Req_A, Data_A, Dp_A, Req_B, Data_B, Dp_B,
        input  Gnt_A, Gnt_B, Frame_tick, An, Cathodes, Dp
    );

    modport slave (
        input  Req_A, Data_A, Dp_A, Req_B, Data_B, Dp_B,
        output Gnt_A, Gnt_B, Frame_tick, An, Cathodes, Dp
    );

endinterface

// File: rtl/ssd_hex_decoder.sv
// ---------------------------------------------------------------------------
// ssd_hex_decoder
//   Combinational 4-bit hex digit to 7-segment active-low cathode decode.
//     nibble_i   hex digit
//     seg_o      {a..g}, active low
// ---------------------------------------------------------------------------
module ssd_hex_decoder
    import ssd_scan_arbiter_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SSD_HEX_SEG[nibble_i];

endmodule

// File: rtl/ssd_scan_arbiter.sv
// ---------------------------------------------------------------------------
// ssd_scan_arbiter
//   Time-multiplexed scan controller for the 8-digit seven-segment display,
//   shared between two requesters. A frame-aligned round-robin arbiter hands
//   the display to A or B. The scanner drives the anodes, the cathodes and DP.
//   Ports:
//     ClkPort   system clock
//     Reset_b   asynchronous active-low reset
//     ssd       ssd_scan_arbiter_if.slave (requests, data, grants, pins)
//   Parameters:
//     DIV_W        prescaler width; one digit tick every 2**DIV_W clocks
//     HOLD_FRAMES  minimum frames an owner keeps the display under contention
//   Optional feature: define SSD_LEADING_ZERO_BLANK_EN to blank zero digits
//   above the most significant non-zero nibble.
// ---------------------------------------------------------------------------
module ssd_scan_arbiter
    import ssd_scan_arbiter_pkg::*;
#(
    parameter int unsigned DIV_W       = 14,
    parameter int unsigned HOLD_FRAMES = 64
) (
    input logic               ClkPort,
    input logic               Reset_b,
    ssd_scan_arbiter_if.slave ssd
);

    localparam int unsigned HOLD_W   = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES - 1);

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [2:0]       digit_q;
    logic             tick;
    logic             frame_end;
    logic             frame_tick_q;

    assign tick      = &div_q;
    assign frame_end = tick && (digit_q == 3'd7);

    always_ff @(posedge ClkPort or negedge Reset_b) begin
        if (!Reset_b) begin
            div_q        <= '0;
            digit_q      <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_q + 1'b1;
            frame_tick_q <= frame_end;
            if (tick) begin
                digit_q <= digit_q + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM: only evaluated on frame_end so that ownership changes
    // always line up with digit 0 of a fresh frame.
    // ------------------------------------------------------------------
    ssd_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              last_b_q, last_b_d;  // 1: B was the most recently granted side
    logic              gnt_a_q, gnt_b_q;
    logic              gnt_a_d, gnt_b_d;

    always_ff @(posedge ClkPort or negedge Reset_b) begin
        if (!Reset_b) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            last_b_q <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            last_b_q <= last_b_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        last_b_d = last_b_q;
        if (frame_end) begin
            case (state_q)
                StIdle: begin
                    if (ssd.Req_A && ssd.Req_B) begin
                        state_d = last_b_q ? StOwnA : StOwnB;
                    end else if (ssd.Req_A) begin
                        state_d = StOwnA;
                    end else if (ssd.Req_B) begin
                        state_d = StOwnB;
                    end
                end
                StOwnA: begin
                    if (!ssd.Req_A) begin
                        state_d = ssd.Req_B ? StOwnB : StIdle;
                    end else if (ssd.Req_B && (hold_q >= HOLD_MAX)) begin
                        state_d = StOwnB;
                    end else if (hold_q < HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                StOwnB: begin
                    if (!ssd.Req_B) begin
                        state_d = ssd.Req_A ? StOwnA : StIdle;
                    end else if (ssd.Req_A && (hold_q >= HOLD_MAX)) begin
                        state_d = StOwnA;
                    end else if (hold_q < HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (state_d != state_q) begin
                hold_d = '0;
                if (state_d == StOwnA) begin
                    last_b_d = 1'b0;
                end else if (state_d == StOwnB) begin
                    last_b_d = 1'b1;
                end
            end
        end
    end

    // Grants are decoded from the next state so that the registered grant
    // changes on the same edge as the state itself.
    always_comb begin
        gnt_a_d = (state_d == StOwnA);
        gnt_b_d = (state_d == StOwnB);
    end

    // ------------------------------------------------------------------
    // Shadow of the owner's word. It is loaded only at frame_end, so a frame
    // never mixes two words even if the requester data moves mid-frame.
    // ------------------------------------------------------------------
    logic [31:0] shadow_data_q, shadow_data_d;
    logic [7:0]  shadow_dp_q, shadow_dp_d;
    logic [7:0]  blank_mask;

    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (frame_end) begin
            case (state_d)
                StOwnA: begin
                    shadow_data_d = ssd.Data_A;
                    shadow_dp_d   = ssd.Dp_A;
                end
                StOwnB: begin
                    shadow_data_d = ssd.Data_B;
                    shadow_dp_d   = ssd.Dp_B;
                end
                default: begin
                    shadow_data_d = '0;
                    shadow_dp_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ClkPort or negedge Reset_b) begin
        if (!Reset_b) begin
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
        end else begin
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
        end
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [7:0] blank_q;

    always_ff @(posedge ClkPort or negedge Reset_b) begin
        if (!Reset_b) begin
            blank_q <= '0;
        end else if (frame_end) begin
            blank_q <= lz_blank_mask(shadow_data_d);
        end
    end

    assign blank_mask = blank_q;
`else
    assign blank_mask = '0;
`endif

    // ------------------------------------------------------------------
    // Output stage: one register between digit index/shadow and the pins.
    // ------------------------------------------------------------------
    logic [3:0] cur_nibble;
    logic [6:0] cur_seg;
    logic [7:0] an_q, an_d;
    logic [6:0] cath_q, cath_d;
    logic       dp_q, dp_d;

    assign cur_nibble = shadow_data_q[{digit_q, 2'b00} +: 4];

    ssd_hex_decoder u_hex_decoder (
        .nibble_i (cur_nibble),
        .seg_o    (cur_seg)
    );

    always_comb begin
        an_d   = 8'hFF;
        cath_d = SSD_BLANK;
        dp_d   = 1'b1;
        if (state_q != StIdle) begin
            an_d   = ~(8'h01 << digit_q);
            cath_d = blank_mask[digit_q] ? SSD_BLANK : cur_seg;
            dp_d   = ~shadow_dp_q[digit_q];
        end
    end

    always_ff @(posedge ClkPort or negedge Reset_b) begin
        if (!Reset_b) begin
            an_q   <= 8'hFF;
            cath_q <= SSD_BLANK;
            dp_q   <= 1'b1;
        end else begin
            an_q   <= an_d;
            cath_q <= cath_d;
            dp_q   <= dp_d;
        end
    end

    assign ssd.Gnt_A      = gnt_a_q;
    assign ssd.Gnt_B      = gnt_b_q;
    assign ssd.Frame_tick = frame_tick_q;
    assign ssd.An         = an_q;
    assign ssd.Cathodes   = cath_q;
    assign ssd.Dp         = dp_q;

endmodule

// File: tb/tb_ssd_scan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_arbiter
//   Bench for ssd_scan_arbiter with DIV_W=2 (4 clocks per digit, 32 per frame)
//   and HOLD_FRAMES=2. A frame-level reference model records, for each frame,
//   which requester owns the display and which word it shows. Every cycle's
//   pins, grants and Frame_tick are compared against that model. It is
//   complemented by a digit decode vector table and hand-written sequences
//   for arbitration, mid-frame release and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_ssd_scan_arbiter;

    localparam int FRAME = 32;
    localparam int DIGIT = 4;
    localparam int HOLD  = 2;
    localparam int NF    = 512;

`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'b0000001;
`endif

    logic board_clk = 1'b0;
    logic reset_b   = 1'b1;

    always #5 board_clk = ~board_clk;

    ssd_scan_arbiter_if ssd_bus ();

    ssd_scan_arbiter #(
        .DIV_W       (2),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .ClkPort (board_clk),
        .Reset_b (reset_b),
        .ssd     (ssd_bus)
    );

    int checks = 0;
    int errors = 0;
    int n      = 0;  // rising edges since the last reset release

    // Frame-level model: owner (0 none, 1 A, 2 B) and the shown word per frame.
    int          own_f  [NF];
    logic [31:0] data_f [NF];
    logic [7:0]  dp_f   [NF];
    int          cur_owner;
    int          held;
    int          last_b;

    logic [6:0] seg_ref [16];

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        int          digit;
        logic [7:0]  an;
        logic [6:0]  cath;
        logic        dpo;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic model_reset();
        n         = 0;
        cur_owner = 0;
        held      = 0;
        last_b    = 1;
        own_f[0]  = 0;
        data_f[0] = '0;
        dp_f[0]   = '0;
    endtask

    // Decide who owns the next frame from the requests present in the last
    // clock of the current frame.
    task automatic decide();
        int   nxt;
        int   f;
        logic a, b;
        a = ssd_bus.Req_A;
        b = ssd_bus.Req_B;
        if (cur_owner != 0) held++;
        nxt = cur_owner;
        case (cur_owner)
            0: begin
                if (a && b)  nxt = (last_b != 0) ? 1 : 2;
                else if (a)  nxt = 1;
                else if (b)  nxt = 2;
            end
            1: begin
                if (!a)                     nxt = b ? 2 : 0;
                else if (b && held >= HOLD) nxt = 2;
            end
            default: begin
                if (!b)                     nxt = a ? 1 : 0;
                else if (a && held >= HOLD) nxt = 1;
            end
        endcase
        if (nxt != cur_owner) begin
            held = 0;
            if (nxt != 0) last_b = (nxt == 2) ? 1 : 0;
        end
        f         = (n + 1) / FRAME;
        own_f[f]  = nxt;
        data_f[f] = (nxt == 1) ? ssd_bus.Data_A : (nxt == 2) ? ssd_bus.Data_B : 32'h0;
        dp_f[f]   = (nxt == 1) ? ssd_bus.Dp_A : (nxt == 2) ? ssd_bus.Dp_B : 8'h00;
        cur_owner = nxt;
    endtask

    // Advance one clock and compare all outputs against the frame model.
    task automatic step();
        int          fp, fg, d, nib;
        logic [31:0] w;
        logic [7:0]  e_an;
        logic [6:0]  e_cath;
        logic        e_dp;
        if (n % FRAME == FRAME - 1) decide();
        @(posedge board_clk);
        n++;
        @(negedge board_clk);
        fp = (n - 1) / FRAME;  // pins lag one clock behind the scan
        fg = n / FRAME;
        d  = ((n - 1) / DIGIT) % 8;
        if (own_f[fp] == 0) begin
            e_an   = 8'hFF;
            e_cath = 7'h7F;
            e_dp   = 1'b1;
        end else begin
            w      = data_f[fp];
            nib    = int'((w >> (4 * d)) & 32'hF);
            e_an   = ~(8'd1 << d);
            e_cath = seg_ref[nib];
`ifdef SSD_LEADING_ZERO_BLANK_EN
            if (d != 0 && (w >> (4 * d)) == 32'h0) e_cath = 7'h7F;
`endif
            e_dp   = ~dp_f[fp][d];
        end
        check("an", 32'(ssd_bus.An), 32'(e_an));
        check("cathodes", 32'(ssd_bus.Cathodes), 32'(e_cath));
        check("dp", 32'(ssd_bus.Dp), 32'(e_dp));
        check("gnt_a", 32'(ssd_bus.Gnt_A), 32'(own_f[fg] == 1));
        check("gnt_b", 32'(ssd_bus.Gnt_B), 32'(own_f[fg] == 2));
        check("frame_tick", 32'(ssd_bus.Frame_tick), 32'(n % FRAME == 0));
    endtask

    task automatic step_to(input int target);
        while (n < target) step();
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_an"}, 32'(ssd_bus.An), 32'h0FF);
        check({tag, "_cath"}, 32'(ssd_bus.Cathodes), 32'h07F);
        check({tag, "_dp"}, 32'(ssd_bus.Dp), 32'h1);
        check({tag, "_gnt_a"}, 32'(ssd_bus.Gnt_A), 32'h0);
        check({tag, "_gnt_b"}, 32'(ssd_bus.Gnt_B), 32'h0);
        check({tag, "_ftick"}, 32'(ssd_bus.Frame_tick), 32'h0);
    endtask

    // Reset asserts between clock edges so the asynchronous path is exercised.
    task automatic do_reset();
        @(negedge board_clk);
        #1 reset_b = 1'b0;
        #1 check_dark("rst");
        @(negedge board_clk);
        @(negedge board_clk);
        reset_b = 1'b1;
        model_reset();
    endtask

    initial begin
        seg_ref = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

        vecs[0]  = '{32'h8765_4321, 8'h01, 0, 8'hFE, 7'b1001111, 1'b0};
        vecs[1]  = '{32'h8765_4321, 8'h01, 7, 8'h7F, 7'b0000000, 1'b1};
        vecs[2]  = '{32'h8765_4321, 8'h01, 4, 8'hEF, 7'b0100100, 1'b1};
        vecs[3]  = '{32'hFEDC_BA98, 8'h80, 7, 8'h7F, 7'b0111000, 1'b0};
        vecs[4]  = '{32'hFEDC_BA98, 8'h80, 0, 8'hFE, 7'b0000000, 1'b1};
        vecs[5]  = '{32'hFEDC_BA98, 8'h80, 3, 8'hF7, 7'b1100000, 1'b1};
        vecs[6]  = '{32'h0000_00A0, 8'h04, 0, 8'hFE, 7'b0000001, 1'b1};
        vecs[7]  = '{32'h0000_00A0, 8'h04, 1, 8'hFD, 7'b0001000, 1'b1};
        vecs[8]  = '{32'h0000_00A0, 8'h04, 2, 8'hFB, LZ_SEG,     1'b0};
        vecs[9]  = '{32'h0000_00A0, 8'h04, 7, 8'h7F, LZ_SEG,     1'b1};
        vecs[10] = '{32'h0000_0000, 8'h00, 0, 8'hFE, 7'b0000001, 1'b1};

        ssd_bus.Req_A  = 1'b0;
        ssd_bus.Data_A = '0;
        ssd_bus.Dp_A   = '0;
        ssd_bus.Req_B  = 1'b0;
        ssd_bus.Data_B = '0;
        ssd_bus.Dp_B   = '0;

        // Idle after reset: dark display for 10 frames, Frame_tick every 32.
        do_reset();
        step_to(10 * FRAME);

        // Digit decode table, A as the only requester.
        for (int i = 0; i < 11; i++) begin
            ssd_bus.Req_A  = 1'b1;
            ssd_bus.Data_A = vecs[i].data;
            ssd_bus.Dp_A   = vecs[i].dp;
            do step(); while (n % FRAME != 0);
            repeat (DIGIT * vecs[i].digit + 3) step();
            check("vec_an", 32'(ssd_bus.An), 32'(vecs[i].an));
            check("vec_cath", 32'(ssd_bus.Cathodes), 32'(vecs[i].cath));
            check("vec_dp", 32'(ssd_bus.Dp), 32'(vecs[i].dpo));
            check("vec_gnt_a", 32'(ssd_bus.Gnt_A), 32'h1);
        end

        // Both requesting from reset: A first, then alternate every 2 frames.
        ssd_bus.Req_A  = 1'b1;
        ssd_bus.Req_B  = 1'b1;
        ssd_bus.Data_A = 32'h1111_1111;
        ssd_bus.Data_B = 32'h2222_2222;
        ssd_bus.Dp_A   = 8'h00;
        ssd_bus.Dp_B   = 8'h00;
        do_reset();
        for (int f = 1; f <= 8; f++) begin
            step_to(f * FRAME + 16);
            check("alt_gnt_a", 32'(ssd_bus.Gnt_A), 32'(((f - 1) / 2) % 2 == 0));
            check("alt_gnt_b", 32'(ssd_bus.Gnt_B), 32'(((f - 1) / 2) % 2 == 1));
        end

        // Mid-frame reset while B owns: everything drops without a clock.
        @(negedge board_clk);
        #1 reset_b = 1'b0;
        #1 check_dark("async");
        @(negedge board_clk);
        reset_b = 1'b1;
        model_reset();
        step_to(FRAME + 16);
        check("restart_gnt_a", 32'(ssd_bus.Gnt_A), 32'h1);
        step_to(3 * FRAME + 16);
        check("restart_gnt_b", 32'(ssd_bus.Gnt_B), 32'h1);

        // A drops mid-frame with B pending: A's word finishes the frame.
        ssd_bus.Req_A = 1'b1;
        ssd_bus.Req_B = 1'b0;
        do_reset();
        step_to(FRAME + 16);
        ssd_bus.Req_A = 1'b0;
        ssd_bus.Req_B = 1'b1;
        step_to(FRAME + 28);
        check("drop_gnt_a_held", 32'(ssd_bus.Gnt_A), 32'h1);
        step_to(2 * FRAME - 1);
        check("drop_last_an", 32'(ssd_bus.An), 32'h7F);
        check("drop_last_cath", 32'(ssd_bus.Cathodes), 32'(7'b1001111));
        step_to(2 * FRAME);
        check("drop_gnt_b", 32'(ssd_bus.Gnt_B), 32'h1);
        check("drop_gnt_a", 32'(ssd_bus.Gnt_A), 32'h0);
        step_to(2 * FRAME + 2);
        check("drop_b_an", 32'(ssd_bus.An), 32'hFE);
        check("drop_b_cath", 32'(ssd_bus.Cathodes), 32'(7'b0010010));

        // Randomised traffic against the frame model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 39) == 0) ssd_bus.Req_A = ~ssd_bus.Req_A;
            if ($urandom_range(0, 39) == 0) ssd_bus.Req_B = ~ssd_bus.Req_B;
            if ($urandom_range(0, 7) == 0) begin
                ssd_bus.Data_A = $urandom;
                ssd_bus.Dp_A   = 8'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                // Some words with leading zeros so the blanking path is hit.
                ssd_bus.Data_B = $urandom >> (4 * $urandom_range(0, 7));
                ssd_bus.Dp_B   = 8'($urandom);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
